// File: rtl/risk_order_arbiter_if.sv
// Shared order/verdict types and the requester/limiter bus of the risk order arbiter.
// The arbiter connects through the slave modport; the surrounding environment uses master.
package risk_pkg;
  typedef enum logic {
    SIDE_BUY  = 1'b0,
    SIDE_SELL = 1'b1
  } order_side_e;

  typedef enum logic [1:0] {
    ORDER_NEW     = 2'd0,
    ORDER_CANCEL  = 2'd1,
    ORDER_REPLACE = 2'd2
  } order_type_e;

  typedef enum logic [1:0] {
    RISK_OK             = 2'd0,
    RISK_POSITION_LIMIT = 2'd1,
    RISK_NOTIONAL_LIMIT = 2'd2,
    RISK_KILL_SWITCH    = 2'd3
  } risk_reject_e;
endpackage

interface risk_order_arbiter_if #(
    parameter int NUM_REQ        = 4,
    parameter int QTY_WIDTH      = 64,
    parameter int NOTIONAL_WIDTH = 64
);
    localparam int SRC_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    risk_pkg::order_side_e     req_side     [NUM_REQ];
    risk_pkg::order_type_e     req_type     [NUM_REQ];
    logic [QTY_WIDTH-1:0]      req_qty      [NUM_REQ];
    logic [NOTIONAL_WIDTH-1:0] req_notional [NUM_REQ];

    logic                      chk_valid;
    logic                      chk_ready;
    risk_pkg::order_side_e     chk_side;
    risk_pkg::order_type_e     chk_type;
    logic [QTY_WIDTH-1:0]      chk_qty;
    logic [NOTIONAL_WIDTH-1:0] chk_notional;
    logic                      chk_passed;
    risk_pkg::risk_reject_e    chk_reason;

    logic                      resp_valid;
    logic [SRC_W-1:0]          resp_src;
    logic                      resp_passed;
    risk_pkg::risk_reject_e    resp_reason;

    modport slave (
        input  req_valid, req_side, req_type, req_qty, req_notional,
        input  chk_ready, chk_passed, chk_reason,
        output req_ready,
        output chk_valid, chk_side, chk_type, chk_qty, chk_notional,
        output resp_valid, resp_src, resp_passed, resp_reason
    );

    modport master (
        output req_valid, req_side, req_type, req_qty, req_notional,
        output chk_ready, chk_passed, chk_reason,
        input  req_ready,
        input  chk_valid, chk_side, chk_type, chk_qty, chk_notional,
        input  resp_valid, resp_src, resp_passed, resp_reason
    );
endinterface

// File: rtl/risk_order_arbiter.sv
// Round-robin arbiter feeding one registered order slot to the position limiter,
// with kill-switch masking of new orders, verdict capture and per-requester counters.
module risk_order_arbiter
    import risk_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int QTY_WIDTH      = 64,
    parameter int NOTIONAL_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      kill_switch,
    risk_order_arbiter_if.slave       bus,
    output logic [NUM_REQ-1:0][31:0]  grant_count,
    output logic [31:0]               kill_blocked
);

    localparam int              SRC_W = $clog2(NUM_REQ);
    localparam logic [SRC_W:0]  NREQ  = (SRC_W+1)'(NUM_REQ);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_e;

    stage_e                     state_q, state_d;
    logic [SRC_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]           src_q, src_d;
    order_side_e                side_q, side_d;
    order_type_e                type_q, type_d;
    logic [QTY_WIDTH-1:0]       qty_q, qty_d;
    logic [NOTIONAL_WIDTH-1:0]  notional_q, notional_d;

    logic                       resp_valid_q, resp_valid_d;
    logic [SRC_W-1:0]           resp_src_q, resp_src_d;
    logic                       resp_passed_q, resp_passed_d;
    risk_reject_e               resp_reason_q, resp_reason_d;

    logic [NUM_REQ-1:0][31:0]   grant_count_q, grant_count_d;
    logic [31:0]                kill_blocked_q, kill_blocked_d;

    logic [NUM_REQ-1:0]         is_new, eligible, elig_rot;
    logic                       masked_new;
    logic                       found;
    logic [SRC_W-1:0]           grant_off, grant_idx, rr_next;
    logic [SRC_W:0]             idx_sum, next_sum;
    logic                       stage_free, grant, chk_fire;

    always_comb begin
        is_new   = '0;
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            is_new[i]   = (bus.req_type[i] == ORDER_NEW);
            eligible[i] = bus.req_valid[i] && !(kill_switch && is_new[i]);
        end
    end

    assign masked_new = kill_switch && |(bus.req_valid & is_new);

    // Rotate so bit 0 is the requester rr_ptr points at; lowest set bit wins.
    assign elig_rot = NUM_REQ'({eligible, eligible} >> rr_ptr_q);

    always_comb begin
        found     = 1'b0;
        grant_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (elig_rot[k]) begin
                found     = 1'b1;
                grant_off = SRC_W'(k);
            end
        end
    end

    assign idx_sum   = {1'b0, rr_ptr_q} + {1'b0, grant_off};
    assign grant_idx = (idx_sum >= NREQ) ? SRC_W'(idx_sum - NREQ) : SRC_W'(idx_sum);
    assign next_sum  = {1'b0, grant_idx} + (SRC_W+1)'(1);
    assign rr_next   = (next_sum == NREQ) ? '0 : SRC_W'(next_sum);

    assign stage_free = (state_q == ST_EMPTY) || bus.chk_ready;
    // Gated by rst_n so no requester sees an accept while reset is held.
    assign grant      = found && stage_free && rst_n;
    assign chk_fire   = (state_q == ST_FULL) && bus.chk_ready;

    assign bus.req_ready = grant ? (NUM_REQ'(1) << grant_idx) : '0;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        src_d         = src_q;
        side_d        = side_q;
        type_d        = type_q;
        qty_d         = qty_q;
        notional_d    = notional_q;
        resp_valid_d  = chk_fire;
        resp_src_d    = resp_src_q;
        resp_passed_d = resp_passed_q;
        resp_reason_d = resp_reason_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (grant) state_d = ST_FULL;
            end
            ST_FULL: begin
                if (grant)         state_d = ST_FULL;
                else if (chk_fire) state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase

        if (grant) begin
            rr_ptr_d   = rr_next;
            src_d      = grant_idx;
            side_d     = bus.req_side[grant_idx];
            type_d     = bus.req_type[grant_idx];
            qty_d      = bus.req_qty[grant_idx];
            notional_d = bus.req_notional[grant_idx];
        end

        if (chk_fire) begin
            resp_src_d    = src_q;
            resp_passed_d = bus.chk_passed;
            resp_reason_d = bus.chk_reason;
        end
    end

    always_comb begin
        grant_count_d  = grant_count_q;
        kill_blocked_d = kill_blocked_q + {31'b0, masked_new};
        if (grant) grant_count_d[grant_idx] = grant_count_q[grant_idx] + 32'd1;
    end

    // Order slot / verdict register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_EMPTY;
            rr_ptr_q       <= '0;
            src_q          <= '0;
            side_q         <= SIDE_BUY;
            type_q         <= ORDER_NEW;
            qty_q          <= '0;
            notional_q     <= '0;
            resp_valid_q   <= 1'b0;
            resp_src_q     <= '0;
            resp_passed_q  <= 1'b0;
            resp_reason_q  <= RISK_OK;
            grant_count_q  <= '0;
            kill_blocked_q <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            src_q          <= src_d;
            side_q         <= side_d;
            type_q         <= type_d;
            qty_q          <= qty_d;
            notional_q     <= notional_d;
            resp_valid_q   <= resp_valid_d;
            resp_src_q     <= resp_src_d;
            resp_passed_q  <= resp_passed_d;
            resp_reason_q  <= resp_reason_d;
            grant_count_q  <= grant_count_d;
            kill_blocked_q <= kill_blocked_d;
        end
    end

    assign bus.chk_valid    = (state_q == ST_FULL);
    assign bus.chk_side     = side_q;
    assign bus.chk_type     = type_q;
    assign bus.chk_qty      = qty_q;
    assign bus.chk_notional = notional_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_src     = resp_src_q;
    assign bus.resp_passed  = resp_passed_q;
    assign bus.resp_reason  = resp_reason_q;
    assign grant_count      = grant_count_q;
    assign kill_blocked     = kill_blocked_q;

endmodule

// File: doc/risk_order_arbiter.md
RISK_ORDER_ARBITER -- requirements
Module: risk_order_arbiter

Interface
REQ-001 Parameters, one per line: NUM_REQ, 4, number of strategy requesters (2..8); QTY_WIDTH, 64, order quantity width; NOTIONAL_WIDTH, 64, order notional width.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  NUM_REQ  per-requester order valid.
REQ-005 req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
REQ-006 req_side / req_type  input  NUM_REQ x order_side_e / order_type_e  per-requester side/type (risk_pkg).
REQ-007 req_qty / req_notional  input  NUM_REQ x QTY_WIDTH / NOTIONAL_WIDTH  per-requester qty/notional.
REQ-008 kill_switch  input  1  level; blocks grant of ORDER_NEW, cancels still flow.
REQ-009 chk_valid / chk_ready  output / input  1 / 1  order handshake to position limiter.
REQ-010 chk_side, chk_type, chk_qty, chk_notional  output  as req_*  registered granted order.
REQ-011 chk_passed / chk_reason  input  1 / risk_reject_e  limiter verdict, combinational on chk_* fields.
REQ-012 resp_valid  output  1  one-cycle verdict pulse.
REQ-013 resp_src  output  $clog2(NUM_REQ)  requester index of verdict.
REQ-014 resp_passed / resp_reason  output  1 / risk_reject_e  captured verdict.
REQ-015 grant_count  output  NUM_REQ x 32  per-requester accepted-order counters.
REQ-016 kill_blocked  output  32  count of cycles an ORDER_NEW was masked by kill_switch.

Function
REQ-017 Output stage is one register slot with states EMPTY (chk_valid=0) and FULL (chk_valid=1).
REQ-018 Eligible requester i: req_valid[i] && !(kill_switch && req_type[i]==ORDER_NEW).
REQ-019 Grant allowed when stage EMPTY, or FULL with chk_ready=1 (same-cycle refill, one order/cycle).
REQ-020 Arbitration round-robin: search from rr_ptr upward with wrap; first eligible index wins.
REQ-021 On grant to i: req_ready[i]=1 (combinational, same cycle), fields captured into stage next edge, src index stored, rr_ptr <= (i+1) mod NUM_REQ.
REQ-022 No grant: rr_ptr unchanged; req_ready all zero.
REQ-023 FULL with chk_ready=0: chk_* fields and src held stable; chk_valid stays 1.
REQ-024 FULL with chk_ready=1 and no grant: next state EMPTY.
REQ-025 On chk_valid && chk_ready: next cycle resp_valid=1, resp_src=stored src, resp_passed/resp_reason=sampled chk_passed/chk_reason; otherwise resp_valid=0.
REQ-026 grant_count[i] increments by 1 per grant to i; wraps modulo 2^32.
REQ-027 kill_blocked increments by 1 each cycle where any req_valid[i] with ORDER_NEW is masked by kill_switch; wraps modulo 2^32.
REQ-028 kill_switch affects only new grants; an ORDER_NEW already in stage completes its handshake.
REQ-029 Latency: request accept to chk_valid = 1 cycle; chk handshake to resp_valid = 1 cycle.

Reset
REQ-030 rst_n low asynchronously forces: stage EMPTY, chk_valid=0, chk_* fields 0, rr_ptr=0, resp_valid=0, resp_src=0, resp_passed=0, resp_reason=RISK_OK, all counters 0.
REQ-031 Reset mid-handshake discards the held order with no response generated; req_ready=0 while rst_n low.

Verification
REQ-032 All 4 requesters valid every cycle, chk_ready=1 -> grants 0,1,2,3,0,... one per cycle; grant_count all 2 after 8 cycles.
REQ-033 Req 2 valid, chk_ready=0 for 5 cycles -> chk_valid=1, chk_qty stable 5 cycles, req_ready=0 after first grant; release -> resp_valid 1 cycle later, resp_src=2.
REQ-034 kill_switch=1, req0 ORDER_NEW, req1 ORDER_CANCEL -> only req1 granted; kill_blocked increments each cycle req0 stays valid.
REQ-035 Limiter returns chk_passed=0, chk_reason=RISK_POSITION_LIMIT for req3 qty=100 -> resp_valid=1, resp_src=3, resp_passed=0, resp_reason=RISK_POSITION_LIMIT.
REQ-036 rst_n asserted while FULL with chk_ready=0 -> chk_valid=0 immediately, no resp_valid after release, rr_ptr=0 (first grant to req0 if all valid).
REQ-037 grant_count[1] preloaded via 2^32-1 grants (or forced) -> next grant wraps to 0.
